dm_dmi_bridge: RTL

Debug-module-side DMI bridge. It pops DMI request packets that the JTAG DTM pushes into the request FIFO, performs one register access per packet on the debug module's internal register bus, and pushes exactly one response packet into the response FIFO for the DTM to collect. It runs entirely in the debug-module clock domain; the FIFOs handle the crossing.

---
 rtl/dm_pkg.sv | 41 ++++
 rtl/dm_dmi_bridge_if.sv | 47 ++++
 rtl/dm_dmi_timeout.sv | 37 +++
 rtl/dm_dmi_bridge.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ============================================================================
// Module      : dm_pkg
// Description : Shared DMI op/status codes, packet layout and bridge states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_pkg;

   typedef enum logic [1:0] {
      DMI_OP_NOP   = 2'd0,
      DMI_OP_READ  = 2'd1,
      DMI_OP_WRITE = 2'd2,
      DMI_OP_RSVD  = 2'd3
   } dmi_op_e;

   localparam logic [1:0] C_STATUS_OK     = 2'd0;
   localparam logic [1:0] C_STATUS_FAILED = 2'd2;

   // Packet layout, LSB first: op/status[2], data[32], addr[ABITS]
   localparam int C_OP_LSB   = 0;
   localparam int C_DATA_LSB = 2;
   localparam int C_ADDR_LSB = 34;

   localparam logic [2:0] C_ST_IDLE  = 3'd0;
   localparam logic [2:0] C_ST_FETCH = 3'd1;
   localparam logic [2:0] C_ST_REQ   = 3'd2;
   localparam logic [2:0] C_ST_WAIT  = 3'd3;
   localparam logic [2:0] C_ST_RESP  = 3'd4;

   function automatic int pkt_width(input int abits);
      return abits + 34;
   endfunction

   function automatic int addr_msb(input int abits);
      return abits + 33;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dm_dmi_bridge_if.sv
// ============================================================================
// Module      : dm_dmi_bridge_if
// Description : FIFO-side and register-bus-side signals of the DMI bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_dmi_bridge_if
   import dm_pkg::*;
#(
   parameter int ABITS = 7
);
   localparam int PW = pkt_width(ABITS);

   logic             req_empty;
   logic             req_ren;
   logic [PW-1:0]    req_data;
   logic             resp_full;
   logic             resp_wen;
   logic [PW-1:0]    resp_data;
   logic             dmi_req_valid;
   logic             dmi_req_ready;
   logic             dmi_req_write;
   logic [ABITS-1:0] dmi_req_addr;
   logic [31:0]      dmi_req_wdata;
   logic             dmi_rsp_valid;
   logic [31:0]      dmi_rsp_rdata;
   logic             dmi_rsp_err;

   // master = the bridge, slave = FIFOs plus debug-module register bus
   modport master (
      input  req_empty, req_data, resp_full,
      input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_rdata, dmi_rsp_err,
      output req_ren, resp_wen, resp_data,
      output dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_wdata
   );

   modport slave (
      output req_empty, req_data, resp_full,
      output dmi_req_ready, dmi_rsp_valid, dmi_rsp_rdata, dmi_rsp_err,
      input  req_ren, resp_wen, resp_data,
      input  dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_wdata
   );

endinterface

`default_nettype wire

// File: rtl/dm_dmi_timeout.sv
// ============================================================================
// Module      : dm_dmi_timeout
// Description : Clear/enable counter that flags the LIMIT-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_dmi_timeout #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int              CW     = $clog2(LIMIT + 1);
   localparam logic [CW-1:0]   C_LAST = CW'(LIMIT - 1);

   logic [CW-1:0] r_cnt;

   // Expiry fires during the LIMIT-th enabled cycle so the caller leaves on that edge
   assign o_expired = i_en && (r_cnt == C_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dm_dmi_bridge.sv
// ============================================================================
// Module      : dm_dmi_bridge
// Description : Pops DMI requests, runs one register-bus access each and pushes
//               one response. Optional WAIT timeout under DM_DMI_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_dmi_bridge
   import dm_pkg::*;
#(
   parameter int ABITS          = 7,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   dm_dmi_bridge_if.master     bus
);
   localparam int PW   = pkt_width(ABITS);
   localparam int AMSB = addr_msb(ABITS);

   logic [2:0]       r_state;
   logic             r_req_ren;
   logic             r_resp_wen;
   logic [PW-1:0]    r_resp_data;
   logic             r_dmi_req_valid;
   logic             r_dmi_req_write;
   logic [ABITS-1:0] r_dmi_req_addr;
   logic [31:0]      r_dmi_req_wdata;

   dmi_op_e          w_op;
   logic [ABITS-1:0] w_req_addr;
   logic [31:0]      w_req_wdata;
   logic [31:0]      w_rsp_data;
   logic [1:0]       w_rsp_status;
   logic             w_timeout;
   logic             w_to_clr;
   logic             w_to_en;

   assign w_op        = dmi_op_e'(bus.req_data[C_OP_LSB +: 2]);
   assign w_req_addr  = bus.req_data[AMSB:C_ADDR_LSB];
   assign w_req_wdata = bus.req_data[C_DATA_LSB +: 32];

   // Only a successful read returns bus data; writes and errors report zero
   assign w_rsp_data   = (bus.dmi_rsp_err || r_dmi_req_write) ? 32'h0 : bus.dmi_rsp_rdata;
   assign w_rsp_status = bus.dmi_rsp_err ? C_STATUS_FAILED : C_STATUS_OK;

   assign w_to_clr = (r_state == C_ST_REQ) && bus.dmi_req_ready;
   assign w_to_en  = (r_state == C_ST_WAIT);

`ifdef DM_DMI_TIMEOUT_EN
   dm_dmi_timeout #(
      .LIMIT     (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_to_clr),
      .i_en      (w_to_en),
      .o_expired (w_timeout)
   );
`else
   assign w_timeout = 1'b0 & w_to_clr & w_to_en;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= C_ST_IDLE;
         r_req_ren       <= 1'b0;
         r_resp_wen      <= 1'b0;
         r_resp_data     <= '0;
         r_dmi_req_valid <= 1'b0;
         r_dmi_req_write <= 1'b0;
         r_dmi_req_addr  <= '0;
         r_dmi_req_wdata <= '0;
      end else begin
         case (r_state)
            C_ST_IDLE: begin
               if (!bus.req_empty) begin
                  r_req_ren <= 1'b1;
                  r_state   <= C_ST_FETCH;
               end
            end

            C_ST_FETCH: begin
               r_req_ren       <= 1'b0;
               r_dmi_req_addr  <= w_req_addr;
               r_dmi_req_wdata <= w_req_wdata;
               r_dmi_req_write <= (w_op == DMI_OP_WRITE);
               // The response FIFO only fills through our own pushes, so a
               // not-full seen now still holds on the push cycle.
               case (w_op)
                  DMI_OP_READ, DMI_OP_WRITE: begin
                     r_dmi_req_valid <= 1'b1;
                     r_state         <= C_ST_REQ;
                  end
                  DMI_OP_NOP: begin
                     r_resp_data <= {w_req_addr, 32'h0, C_STATUS_OK};
                     r_resp_wen  <= !bus.resp_full;
                     r_state     <= C_ST_RESP;
                  end
                  default: begin
                     r_resp_data <= {w_req_addr, 32'h0, C_STATUS_FAILED};
                     r_resp_wen  <= !bus.resp_full;
                     r_state     <= C_ST_RESP;
                  end
               endcase
            end

            C_ST_REQ: begin
               if (bus.dmi_req_ready) begin
                  r_dmi_req_valid <= 1'b0;
                  r_state         <= C_ST_WAIT;
               end
            end

            C_ST_WAIT: begin
               if (bus.dmi_rsp_valid) begin
                  r_resp_data <= {r_dmi_req_addr, w_rsp_data, w_rsp_status};
                  r_resp_wen  <= !bus.resp_full;
                  r_state     <= C_ST_RESP;
               end else if (w_timeout) begin
                  r_resp_data <= {r_dmi_req_addr, 32'h0, C_STATUS_FAILED};
                  r_resp_wen  <= !bus.resp_full;
                  r_state     <= C_ST_RESP;
               end
            end

            C_ST_RESP: begin
               if (r_resp_wen) begin
                  r_resp_wen <= 1'b0;
                  r_state    <= C_ST_IDLE;
               end else if (!bus.resp_full) begin
                  r_resp_wen <= 1'b1;
               end
            end

            default: begin
               r_state <= C_ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ren       = r_req_ren;
   assign bus.resp_wen      = r_resp_wen;
   assign bus.resp_data     = r_resp_data;
   assign bus.dmi_req_valid = r_dmi_req_valid;
   assign bus.dmi_req_write = r_dmi_req_write;
   assign bus.dmi_req_addr  = r_dmi_req_addr;
   assign bus.dmi_req_wdata = r_dmi_req_wdata;

endmodule

`default_nettype wire
